// File: rtl/jtag_sba_mem_responder.sv
// jtag_sba_mem_responder: req/gnt/rvalid SRAM responder with programmable grant and response delays.
// One transaction in flight; byte-enabled writes; out-of-range accesses answer with err=1, rdata=0.
module jtag_sba_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          GNT_DELAY = 0,
  parameter int          RSP_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slave_req_i,
  output logic        slave_gnt_o,
  input  logic        slave_we_i,
  input  logic [3:0]  slave_be_i,
  input  logic [31:0] slave_addr_i,
  input  logic [31:0] slave_wdata_i,
  output logic        slave_rvalid_o,
  output logic [31:0] slave_rdata_o,
  output logic        slave_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] S_IDLE     = 4'b0001;
  localparam logic [3:0] S_GNT_WAIT = 4'b0010;
  localparam logic [3:0] S_RSP_WAIT = 4'b0100;
  localparam logic [3:0] S_RSP      = 4'b1000;

  logic [31:0]   mem [DEPTH];
  logic [3:0]    state_q, state_d;
  logic [3:0]    gnt_cnt_q, gnt_cnt_d;
  logic [3:0]    rsp_cnt_q, rsp_cnt_d;
  logic [31:0]   rsp_data_q, rdata_q;
  logic          rsp_err_q, err_q;
  logic [31:0]   offset, acc_data;
  logic [AW-1:0] idx;
  logic          in_range, accept;

  assign offset   = slave_addr_i - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign acc_data = (in_range && !slave_we_i) ? mem[idx] : 32'd0;
  assign accept   = slave_req_i && slave_gnt_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_cnt_q  <= gnt_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      rsp_data_q <= accept ? acc_data : rsp_data_q;
      rsp_err_q  <= accept ? !in_range : rsp_err_q;
      // Output registers only change on entry to S_RSP so rdata holds between responses.
      rdata_q    <= (state_d == S_RSP) ? (accept ? acc_data : rsp_data_q) : rdata_q;
      err_q      <= (state_d == S_RSP) ? (accept ? !in_range : rsp_err_q) : err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && slave_we_i && in_range)
      for (int i = 0; i < 4; i++)
        if (slave_be_i[i]) mem[idx][8*i +: 8] <= slave_wdata_i[8*i +: 8];
  end

  always_comb begin
    state_d   = state_q;
    gnt_cnt_d = gnt_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    if (accept) begin
      state_d   = (RSP_DELAY == 1) ? S_RSP : S_RSP_WAIT;
      rsp_cnt_d = 4'(RSP_DELAY - 1);
    end else if (state_q == S_IDLE && slave_req_i) begin
      state_d   = S_GNT_WAIT;
      gnt_cnt_d = 4'(GNT_DELAY - 1);
    end else if (state_q == S_GNT_WAIT) begin
      state_d   = slave_req_i ? S_GNT_WAIT : S_IDLE;
      gnt_cnt_d = slave_req_i ? gnt_cnt_q - 4'd1 : 4'd0;
    end else if (state_q == S_RSP_WAIT) begin
      state_d   = (rsp_cnt_q == 4'd1) ? S_RSP : S_RSP_WAIT;
      rsp_cnt_d = rsp_cnt_q - 4'd1;
    end else if (state_q == S_RSP) begin
      state_d   = S_IDLE;
    end
  end

  always_comb begin
    slave_gnt_o    = rst_n && slave_req_i &&
                     ((state_q == S_IDLE && GNT_DELAY == 0) || (state_q == S_GNT_WAIT && gnt_cnt_q == 4'd0));
    slave_rvalid_o = state_q == S_RSP;
    slave_rdata_o  = rdata_q;
    slave_err_o    = err_q;
  end
endmodule

// File: tb/tb_jtag_sba_mem_responder.sv
// tb_jtag_sba_mem_responder: three responders with different delays; stimulus pushes expected
// grant/response cycles into queues and a single negedge monitor pops and compares them.
module tb_jtag_sba_mem_responder;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int GD[3] = '{0, 3, 2};
  localparam int RD[3] = '{1, 4, 2};

  typedef struct {int k; int cyc; logic [31:0] data; logic err;} exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  gnt, rvalid, err;
  logic [31:0] rdata [3];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  logic        done = 1'b0;
  exp_t        gq[$];
  exp_t        rq[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jtag_sba_mem_responder #(.BASE_ADDR(BASE), .DEPTH(16), .GNT_DELAY(GD[g]), .RSP_DELAY(RD[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .slave_req_i(req[g]), .slave_gnt_o(gnt[g]), .slave_we_i(we),
      .slave_be_i(be), .slave_addr_i(addr), .slave_wdata_i(wdata), .slave_rvalid_o(rvalid[g]),
      .slave_rdata_o(rdata[g]), .slave_err_o(err[g]));
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk("rst_gnt", 32'(gnt[k]), 32'd0);
        chk("rst_rvalid", 32'(rvalid[k]), 32'd0);
        chk("rst_rdata", rdata[k], 32'd0);
        chk("rst_err", 32'(err[k]), 32'd0);
      end else begin
        if (gnt[k]) begin
          if (gq.size() == 0 || gq[0].k != k) chk("gnt_unexpected", 32'(gnt[k]), 32'd0);
          else begin
            chk("gnt_cycle", 32'(cyc), 32'(gq[0].cyc));
            void'(gq.pop_front());
          end
        end
        if (rvalid[k]) begin
          if (rq.size() == 0 || rq[0].k != k) chk("rvalid_unexpected", 32'(rvalid[k]), 32'd0);
          else begin
            chk("rvalid_cycle", 32'(cyc), 32'(rq[0].cyc));
            chk("rdata", rdata[k], rq[0].data);
            chk("err", 32'(err[k]), 32'(rq[0].err));
            void'(rq.pop_front());
          end
        end
      end
    end
    if (done) begin
      chk("gnt_pending", 32'(gq.size()), 32'd0);
      chk("rsp_pending", 32'(rq.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
    end
  end

  task automatic wait_gnt(input int k);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt[k]) break;
    end
  endtask

  task automatic xact(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] ed, input logic ee, input logic rst_mid);
    int c;
    @(posedge clk);
    #1;
    we = w; be = b; addr = a; wdata = d; req[k] = 1'b1; c = cyc;
    gq.push_back('{k, c + GD[k], 32'd0, 1'b0});
    if (!rst_mid) rq.push_back('{k, c + GD[k] + RD[k], ed, ee});
    wait_gnt(k);
    @(posedge clk);
    #1 req[k] = 1'b0;
    if (rst_mid) begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end
    repeat (RD[k] + 2) @(posedge clk);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Zero-delay responder: basic write/read, byte enables, range edges
    xact(0, 1, 4'hF, BASE + 8,     32'hDEAD_BEEF, 32'h0,         0, 0);
    xact(0, 0, 4'hF, BASE + 8,     32'h0,         32'hDEAD_BEEF, 0, 0);
    xact(0, 1, 4'hF, BASE + 12,    32'h1122_3344, 32'h0,         0, 0);
    xact(0, 1, 4'h5, BASE + 12,    32'hAABB_CCDD, 32'h0,         0, 0);
    xact(0, 0, 4'h0, BASE + 12,    32'h0,         32'h11BB_33DD, 0, 0);
    xact(0, 1, 4'hF, BASE + 32'h3C, 32'hCAFE_F00D, 32'h0,        0, 0);
    xact(0, 0, 4'hF, BASE + 32'h3C, 32'h0,        32'hCAFE_F00D, 0, 0);
    xact(0, 0, 4'hF, BASE + 32'h40, 32'h0,        32'h0,         1, 0);
    xact(0, 1, 4'hF, BASE - 4,     32'h1234_5678, 32'h0,         1, 0);
    xact(0, 0, 4'hF, BASE + 32'h3C, 32'h0,        32'hCAFE_F00D, 0, 0);
    xact(0, 1, 4'h0, BASE + 8,     32'h0BAD_0BAD, 32'h0,         0, 0);
    xact(0, 0, 4'hF, BASE + 8,     32'h0,         32'hDEAD_BEEF, 0, 0);
    // req held high across a response: re-accepted two cycles after the first grant
    @(posedge clk);
    #1;
    we = 0; addr = BASE + 8; req[0] = 1'b1; c = cyc;
    gq.push_back('{0, c, 32'd0, 1'b0});
    gq.push_back('{0, c + 2, 32'd0, 1'b0});
    rq.push_back('{0, c + 1, 32'hDEAD_BEEF, 1'b0});
    rq.push_back('{0, c + 3, 32'hDEAD_BEEF, 1'b0});
    wait_gnt(0);
    wait_gnt(0);
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (3) @(posedge clk);
    // Delayed responder: grant at +3, response at +7, reset while response pending
    xact(1, 1, 4'hF, BASE + 4,     32'h5A5A_5A5A, 32'h0,         0, 0);
    xact(1, 0, 4'hF, BASE + 4,     32'h0,         32'h5A5A_5A5A, 0, 0);
    xact(1, 1, 4'hF, BASE + 16,    32'h0F0F_0F0F, 32'h0,         0, 1);
    xact(1, 0, 4'hF, BASE + 16,    32'h0,         32'h0F0F_0F0F, 0, 0);
    // Grant-delay 2: request withdrawn after one cycle, then a normal transaction
    @(posedge clk);
    #1;
    we = 1; be = 4'hF; addr = BASE; wdata = 32'hFFFF_FFFF; req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    repeat (6) @(posedge clk);
    xact(2, 1, 4'hF, BASE,         32'h7777_0001, 32'h0,         0, 0);
    xact(2, 0, 4'hF, BASE,         32'h0,         32'h7777_0001, 0, 0);
    repeat (4) @(posedge clk);
    #1 done = 1'b1;
  end
endmodule
